// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory view.
interface mem_port_arbiter_if #(
   parameter int AW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_kill;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;

   logic          dm_req;
   logic          dm_we;
   logic [3:0]    dm_be;
   logic [AW-1:0] dm_addr;
   logic [31:0]   dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [31:0]   dm_rdata;

   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr, if_kill,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_kill,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch (IF) and load/store (DM) ports:
// fixed data priority with a fetch anti-starvation override, fixed-latency read return.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);

   logic [3:0]         r_starve_cnt;
   logic [MEM_LAT-1:0] r_vld;
   logic [MEM_LAT-1:0] r_own_dm;
   logic [MEM_LAT-1:0] w_vld_next;
   logic [MEM_LAT-1:0] w_own_next;

   logic w_starved;
   logic w_dm_gnt;
   logic w_if_gnt;
   logic w_rd_issue;
   logic w_exit_vld;
   logic w_if_rvalid;
   logic w_dm_rvalid;

   // Grants are gated by rst so every output is quiet while reset is held.
   assign w_starved  = (r_starve_cnt == 4'(STARVE_MAX));
   assign w_dm_gnt   = ~rst & bus.dm_req & ~(bus.if_req & w_starved);
   assign w_if_gnt   = ~rst & bus.if_req & ~w_dm_gnt;
   assign w_rd_issue = w_if_gnt | (w_dm_gnt & ~bus.dm_we);

   assign bus.if_gnt = w_if_gnt;
   assign bus.dm_gnt = w_dm_gnt;

   always_comb begin
      bus.mem_en    = w_if_gnt | w_dm_gnt;
      bus.mem_we    = 4'b0000;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (w_dm_gnt) begin
         bus.mem_we    = bus.dm_we ? bus.dm_be : 4'b0000;
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
      end else if (w_if_gnt) begin
         bus.mem_addr  = bus.if_addr;
      end
   end

   // Read tracker: stage 0 takes the read granted this cycle (never killed, it is the
   // redirected fetch); later stages drop IF-owned entries when a kill is seen.
   generate
      for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign w_vld_next[gi] = w_rd_issue;
            assign w_own_next[gi] = w_dm_gnt;
         end else begin : g_body
            assign w_vld_next[gi] = r_vld[gi-1] & ~(bus.if_kill & ~r_own_dm[gi-1]);
            assign w_own_next[gi] = r_own_dm[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld    <= '0;
         r_own_dm <= '0;
      end else begin
         r_vld    <= w_vld_next;
         r_own_dm <= w_own_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else if (~bus.if_req | w_if_gnt) begin
         r_starve_cnt <= 4'd0;
      end else if (!w_starved) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   // A fetch exiting in the kill cycle is stale, so its pulse is suppressed too.
   assign w_exit_vld  = r_vld[MEM_LAT-1] & ~rst;
   assign w_if_rvalid = w_exit_vld & ~r_own_dm[MEM_LAT-1] & ~bus.if_kill;
   assign w_dm_rvalid = w_exit_vld &  r_own_dm[MEM_LAT-1];

   assign bus.if_rvalid = w_if_rvalid;
   assign bus.dm_rvalid = w_dm_rvalid;
   assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.dm_rdata  = w_dm_rvalid ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives identical directed stimulus into two arbiters (MEM_LAT=1 and MEM_LAT=3), each with its
// own memory model; expected responses are queued per instance and checked by a monitor.
module tb_mem_port_arbiter;

   typedef struct {
      logic        own_dm;
      logic [31:0] data;
      int          due;
   } resp_t;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;

   logic [1:0]  if_gnt_o;
   logic [1:0]  dm_gnt_o;
   logic [1:0]  mem_en_o;
   logic [1:0]  if_rvalid_o;
   logic [1:0]  dm_rvalid_o;
   logic [1:0]  any_o;
   logic [31:0] if_rdata_o  [2];
   logic [31:0] dm_rdata_o  [2];
   logic [31:0] mem_addr_o  [2];
   logic [31:0] mem_wdata_o [2];
   logic [3:0]  mem_we_o    [2];

   resp_t exp_q [2][$];
   int    checks = 0;
   int    errors = 0;
   int    cycle  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      mem_port_arbiter_if #(.AW(32)) bus ();
      logic [31:0] mem [0:255];
      logic [31:0] rd_pipe [LAT];
      resp_t       mon_e;
      logic        got_dm;
      logic [31:0] got_data;
      logic [31:0] other_data;

      assign bus.if_req    = if_req;
      assign bus.if_addr   = if_addr;
      assign bus.if_kill   = if_kill;
      assign bus.dm_req    = dm_req;
      assign bus.dm_we     = dm_we;
      assign bus.dm_be     = dm_be;
      assign bus.dm_addr   = dm_addr;
      assign bus.dm_wdata  = dm_wdata;
      assign bus.mem_rdata = rd_pipe[LAT-1];

      mem_port_arbiter #(.AW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign if_gnt_o[gi]    = bus.if_gnt;
      assign dm_gnt_o[gi]    = bus.dm_gnt;
      assign mem_en_o[gi]    = bus.mem_en;
      assign if_rvalid_o[gi] = bus.if_rvalid;
      assign dm_rvalid_o[gi] = bus.dm_rvalid;
      assign if_rdata_o[gi]  = bus.if_rdata;
      assign dm_rdata_o[gi]  = bus.dm_rdata;
      assign mem_addr_o[gi]  = bus.mem_addr;
      assign mem_wdata_o[gi] = bus.mem_wdata;
      assign mem_we_o[gi]    = bus.mem_we;
      assign any_o[gi] = |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.dm_gnt, bus.dm_rvalid,
                           bus.dm_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};

      // Word i holds {A5, i, 5A, i}.
      initial for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i), 8'h5A, 8'(i)};

      always @(posedge clk) begin
         if (bus.mem_en) begin
            rd_pipe[0] <= mem[bus.mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
               if (bus.mem_we[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
         for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
      end

      always @(negedge clk) begin
         if (!rst) begin
            if (if_rvalid_o[gi] || dm_rvalid_o[gi]) begin
               checks++;
               got_dm     = dm_rvalid_o[gi];
               got_data   = got_dm ? dm_rdata_o[gi] : if_rdata_o[gi];
               other_data = got_dm ? if_rdata_o[gi] : dm_rdata_o[gi];
               if (exp_q[gi].size() == 0) begin
                  errors++;
                  $display("FAIL rsp lat%0d cyc %0d: unexpected if_rvalid=%b dm_rvalid=%b, required none",
                           LAT, cycle, if_rvalid_o[gi], dm_rvalid_o[gi]);
               end else begin
                  mon_e = exp_q[gi].pop_front();
                  if ((if_rvalid_o[gi] && dm_rvalid_o[gi]) || got_dm !== mon_e.own_dm ||
                      got_data !== mon_e.data || other_data !== 32'd0 || cycle != mon_e.due) begin
                     errors++;
                     $display("FAIL rsp lat%0d: got cyc=%0d if_rv=%b dm_rv=%b data=%h other=%h, required cyc=%0d dm=%b data=%h other=0",
                              LAT, cycle, if_rvalid_o[gi], dm_rvalid_o[gi], got_data, other_data,
                              mon_e.due, mon_e.own_dm, mon_e.data);
                  end else begin
                     $display("rsp lat%0d cyc %0d %s data=%h", LAT, cycle, got_dm ? "DM" : "IF", got_data);
                  end
               end
            end else if (exp_q[gi].size() != 0 && exp_q[gi][0].due <= cycle) begin
               checks++;
               errors++;
               mon_e = exp_q[gi].pop_front();
               $display("FAIL rsp lat%0d cyc %0d: no rvalid, required dm=%b data=%h at cyc %0d",
                        LAT, cycle, mon_e.own_dm, mon_e.data, mon_e.due);
            end
         end
      end
   end

   task automatic set_if(input logic req, input logic [31:0] addr, input logic kill);
      if_req  = req;
      if_addr = addr;
      if_kill = kill;
   endtask

   task automatic set_dm(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      dm_req   = req;
      dm_we    = we;
      dm_be    = be;
      dm_addr  = addr;
      dm_wdata = wdata;
   endtask

   // Drop expected responses due this cycle or later (IF-only for a kill, all for a reset).
   task automatic prune(input bit all_owners);
      for (int k = 0; k < 2; k++)
         for (int i = exp_q[k].size() - 1; i >= 0; i--)
            if ((all_owners || !exp_q[k][i].own_dm) && exp_q[k][i].due >= cycle)
               exp_q[k].delete(i);
   endtask

   task automatic cyc(input logic eif, input logic edm, input logic [3:0] ewe, input logic [31:0] edata);
      logic [31:0] eaddr;
      logic [31:0] ewdata;
      if (if_kill) prune(1'b0);
      @(negedge clk);
      eaddr  = edm ? dm_addr : (eif ? if_addr : 32'd0);
      ewdata = edm ? dm_wdata : 32'd0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (if_gnt_o[k] !== eif || dm_gnt_o[k] !== edm || mem_en_o[k] !== (eif | edm) ||
             mem_we_o[k] !== ewe || mem_addr_o[k] !== eaddr || mem_wdata_o[k] !== ewdata) begin
            errors++;
            $display("FAIL gnt lat%0d cyc %0d: got if_gnt=%b dm_gnt=%b en=%b we=%b addr=%h wd=%h, required %b %b %b %b %h %h",
                     lat_of(k), cycle, if_gnt_o[k], dm_gnt_o[k], mem_en_o[k], mem_we_o[k], mem_addr_o[k],
                     mem_wdata_o[k], eif, edm, eif | edm, ewe, eaddr, ewdata);
         end
         if (eif || (edm && !dm_we))
            exp_q[k].push_back('{own_dm: edm, data: edata, due: cycle + lat_of(k)});
      end
      if (eif || edm)
         $display("req cyc %0d %s addr=%h we=%b", cycle, edm ? "DM" : "IF", eaddr, ewe);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'b0000, 32'd0);
   endtask

   task automatic chk_rst();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (any_o[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset lat%0d cyc %0d: some output=%b, required all 0", lat_of(k), cycle, any_o[k]);
         end else begin
            $display("reset lat%0d cyc %0d outputs 0", lat_of(k), cycle);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_if(1'b1, 32'h10, 1'b0);
      set_dm(1'b1, 1'b0, 4'b0000, 32'h20, 32'd0);
      @(posedge clk);
      #1;
      chk_rst();
      chk_rst();
      rst = 1'b0;
      set_if(1'b0, 32'd0, 1'b0);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      idle(1);

      // Back-to-back fetches.
      set_if(1'b1, 32'h0, 1'b0); cyc(1'b1, 1'b0, 4'b0000, 32'hA500_5A00);
      set_if(1'b1, 32'h4, 1'b0); cyc(1'b1, 1'b0, 4'b0000, 32'hA501_5A01);
      set_if(1'b1, 32'h8, 1'b0); cyc(1'b1, 1'b0, 4'b0000, 32'hA502_5A02);
      set_if(1'b0, 32'h0, 1'b0); idle(4);

      // Simultaneous requests: data wins, fetch next cycle.
      set_if(1'b1, 32'h10, 1'b0);
      set_dm(1'b1, 1'b0, 4'b0000, 32'h100, 32'd0); cyc(1'b0, 1'b1, 4'b0000, 32'hA540_5A40);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);   cyc(1'b1, 1'b0, 4'b0000, 32'hA504_5A04);
      set_if(1'b0, 32'h0, 1'b0); idle(4);

      // Starvation override: fetch wins on the 5th and 10th contended cycles.
      set_if(1'b1, 32'h20, 1'b0);
      set_dm(1'b1, 1'b0, 4'b0000, 32'h104, 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            cyc(1'b1, 1'b0, 4'b0000, 32'hA508_5A08);
            set_if(1'b1, 32'h24, 1'b0);
         end else if (i == 9) begin
            cyc(1'b1, 1'b0, 4'b0000, 32'hA509_5A09);
         end else begin
            cyc(1'b0, 1'b1, 4'b0000, 32'hA541_5A41);
         end
      end
      set_if(1'b0, 32'h0, 1'b0);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      idle(4);

      // Partial store then load back.
      set_dm(1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF); cyc(1'b0, 1'b1, 4'b0011, 32'd0);
      set_dm(1'b1, 1'b0, 4'b0000, 32'h40, 32'd0);         cyc(1'b0, 1'b1, 4'b0000, 32'hA510_BEEF);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      idle(4);

      // Kill with a redirected fetch in the same cycle.
      set_if(1'b1, 32'h80, 1'b0);  cyc(1'b1, 1'b0, 4'b0000, 32'hA520_5A20);
      set_if(1'b1, 32'h84, 1'b0);  cyc(1'b1, 1'b0, 4'b0000, 32'hA521_5A21);
      set_if(1'b1, 32'h200, 1'b1); cyc(1'b1, 1'b0, 4'b0000, 32'hA580_5A80);
      set_if(1'b0, 32'h0, 1'b0);   idle(5);

      // Kill leaves an in-flight load alone.
      set_dm(1'b1, 1'b0, 4'b0000, 32'h100, 32'd0); cyc(1'b0, 1'b1, 4'b0000, 32'hA540_5A40);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      set_if(1'b1, 32'h84, 1'b0); cyc(1'b1, 1'b0, 4'b0000, 32'hA521_5A21);
      set_if(1'b0, 32'h0, 1'b1);  cyc(1'b0, 1'b0, 4'b0000, 32'd0);
      set_if(1'b0, 32'h0, 1'b0);  idle(5);

      // Reset with reads in flight.
      set_if(1'b1, 32'h0, 1'b0); cyc(1'b1, 1'b0, 4'b0000, 32'hA500_5A00);
      set_if(1'b0, 32'h0, 1'b0);
      set_dm(1'b1, 1'b0, 4'b0000, 32'h4, 32'd0); cyc(1'b0, 1'b1, 4'b0000, 32'hA501_5A01);
      rst = 1'b1;
      set_if(1'b1, 32'h8, 1'b0);
      prune(1'b1);
      chk_rst();
      chk_rst();
      set_if(1'b0, 32'h0, 1'b0);
      set_dm(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      rst = 1'b0;
      idle(5);

      for (int k = 0; k < 2; k++) begin
         checks++;
         if (exp_q[k].size() != 0) begin
            errors++;
            $display("FAIL drain lat%0d: %0d responses outstanding, required 0", lat_of(k), exp_q[k].size());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
